// File: rtl/mem_op_pkg.sv
// Shared types and helpers for the load/store/atomic memory-op unit.
package mem_op_pkg;

    typedef enum logic [3:0] {
        LOAD, STORE, LR, SC,
        AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
        AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU
    } op_e;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP
    } state_e;

    // req_size[1:0] is log2 of the access width; req_size[2] requests zero-extension
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam int SZ_ZEXT_BIT = 2;

    function automatic logic is_amo(input op_e op);
        return (op >= AMO_ADD) && (op <= AMO_MAXU);
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/mem_op_unit_amo_alu.sv
// Combinational AMO datapath: new = f(old, operand) at 32- or XLEN-bit width.
module amo_alu
    import mem_op_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  op_e             op_i,
    input  logic            w64_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] new_o
);

    int unsigned            sh;
    logic signed [XLEN-1:0] old_s, opnd_s;
    logic        [XLEN-1:0] old_u, opnd_u;

    always_comb begin
        // Narrow ops compare on the low 32 bits only, so re-extend them to full width
        sh     = w64_i ? 0 : XLEN - 32;
        old_s  = $signed(old_i << sh) >>> sh;
        opnd_s = $signed(opnd_i << sh) >>> sh;
        old_u  = (old_i << sh) >> sh;
        opnd_u = (opnd_i << sh) >> sh;

        new_o = old_i;
        case (op_i)
            AMO_ADD:  new_o = old_i + opnd_i;
            AMO_SWAP: new_o = opnd_i;
            AMO_XOR:  new_o = old_i ^ opnd_i;
            AMO_OR:   new_o = old_i | opnd_i;
            AMO_AND:  new_o = old_i & opnd_i;
            AMO_MIN:  new_o = (old_s <= opnd_s) ? old_i : opnd_i;
            AMO_MAX:  new_o = (old_s >= opnd_s) ? old_i : opnd_i;
            AMO_MINU: new_o = (old_u <= opnd_u) ? old_i : opnd_i;
            AMO_MAXU: new_o = (old_u >= opnd_u) ? old_i : opnd_i;
            default:  new_o = old_i;
        endcase
    end

endmodule

// File: rtl/mem_op_unit.sv
// Load/store/LR/SC/AMO execution unit driving a single XLEN-wide memory port.
module mem_op_unit
    import mem_op_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int AW       = 64,
    parameter int RSV_GRAN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  op_e               req_op,
    input  logic [2:0]        req_size,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              snoop_valid,
    input  logic [AW-1:0]     snoop_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int GW   = AW - RSV_GRAN;

    state_e            state_q;
    logic              err_q;
    logic              rsv_valid_q;
    logic [GW-1:0]     rsv_gran_q;
    op_e               op_q;
    logic [2:0]        size_q;
    logic [AW-1:0]     addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   res_q;
    logic [XLEN-1:0]   new_q;

    logic              req_bad_d;
    logic              sc_hit_d;
    logic [OFFW-1:0]   off_d;
    logic [XLEN-1:0]   lane_d;
    logic [XLEN-1:0]   old_d;
    logic [XLEN-1:0]   alu_new_d;
    logic [XLEN-1:0]   wr_opnd_d;
    logic [NB-1:0]     wmask_base_d;
    logic              unused_snoop_lo;

    function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] sz);
        logic [XLEN-1:0] ones;
        ones = '1;
        return (sz == SZ_D) ? ones : ~(ones << (8 << sz));
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] val,
                                               input logic [1:0]      sz,
                                               input logic            zext);
        logic [XLEN-1:0] m, v, sbit;
        m    = lane_mask(sz);
        v    = val & m;
        sbit = XLEN'(1) << ((8 << sz) - 1);
        return (!zext && ((v & sbit) != '0)) ? (v | ~m) : v;
    endfunction

    always_comb begin
        req_bad_d = ((req_size[1:0] == SZ_D) && (XLEN < 64))
                  || (req_op > AMO_MAXU)
                  || ((req_addr & (AW'(size_bytes(req_size[1:0])) - AW'(1))) != '0);
        sc_hit_d  = rsv_valid_q && (rsv_gran_q == req_addr[AW-1:RSV_GRAN]);
    end

    assign unused_snoop_lo = ^snoop_addr[RSV_GRAN-1:0];

    assign off_d  = addr_q[OFFW-1:0];
    assign lane_d = mem_rdata >> {off_d, 3'b000};
    // LR.W and AMO.W results are sign-extended even when the zero-extend bit is set
    assign old_d  = extend(lane_d, size_q[1:0],
                           size_q[SZ_ZEXT_BIT] && (op_q != LR) && !is_amo(op_q));

    amo_alu #(.XLEN(XLEN)) u_amo_alu (
        .op_i   (op_q),
        .w64_i  (size_q[1:0] == SZ_D),
        .old_i  (lane_d),
        .opnd_i (wdata_q),
        .new_o  (alu_new_d)
    );

    assign wr_opnd_d    = (is_amo(op_q) ? new_q : wdata_q) & lane_mask(size_q[1:0]);
    assign wmask_base_d = NB'((16'd1 << size_bytes(size_q[1:0])) - 16'd1);

    assign req_ready = (state_q == IDLE);
    assign mem_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we    = (state_q == WR_REQ);
    assign mem_addr  = mem_valid ? {addr_q[AW-1:OFFW], {OFFW{1'b0}}} : '0;
    assign mem_wdata = mem_we ? (wr_opnd_d << {off_d, 3'b000}) : '0;
    assign mem_wmask = mem_we ? (wmask_base_d << off_d) : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_valid ? res_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            rsv_valid_q <= 1'b0;
            rsv_gran_q  <= '0;
        end else begin
            if (snoop_valid && (snoop_addr[AW-1:RSV_GRAN] == rsv_gran_q))
                rsv_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        err_q <= req_bad_d;
                        if (req_op == SC)
                            rsv_valid_q <= 1'b0;
                        if (req_bad_d)
                            state_q <= RESP;
                        else if (req_op == STORE)
                            state_q <= WR_REQ;
                        else if (req_op == SC)
                            state_q <= sc_hit_d ? WR_REQ : RESP;
                        else
                            state_q <= RD_REQ;
                    end
                end
                RD_REQ: if (mem_ready) state_q <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= is_amo(op_q) ? WR_REQ : RESP;
                        // Placed after the snoop clear so a same-cycle LR capture wins
                        if (op_q == LR) begin
                            rsv_valid_q <= 1'b1;
                            rsv_gran_q  <= addr_q[AW-1:RSV_GRAN];
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_ready) begin
                        state_q <= RESP;
                        if (rsv_gran_q == addr_q[AW-1:RSV_GRAN])
                            rsv_valid_q <= 1'b0;
                    end
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && req_valid) begin
            op_q    <= req_op;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            res_q   <= XLEN'((req_op == SC) && !sc_hit_d && !req_bad_d);
        end
        if ((state_q == RD_WAIT) && mem_rvalid) begin
            res_q <= old_d;
            new_q <= alu_new_d;
        end
    end

endmodule
